seg7_scan_mux: RTL and testbench
================================

// Module: seg7_scan_mux
// PURPOSE
//  Multi-digit, time-multiplexed 7-segment display driver. It succeeds the single-digit
//  combinational BCD decoder. Double-buffers DIGITS packed BCD/hex nibbles and scans them
//  onto one shared common-anode segment bus, one digit per slot. Adds decimal points,
//  leading-zero blanking, anti-ghost blanking and tear-free frame-aligned updates.
//  Sits between the counter/datapath logic and the board display pins.
// PARAMETERS
//  DIGITS    4      number of digits, 1..8; digit 0 = least significant
//  SCAN_DIV  50000  clocks per digit slot, >=2
//  BLANK_CYC 2      clocks at the start of each slot with all digit enables off; 0..SCAN_DIV-1
//  HEX_EN    0      1: nibbles 10..15 show A,b,C,d,E,F; 0: they show blank
//  DIG_ACT_LO 1     1: dig_sel active-low; 0: active-high
// PORTS
//  clk        in   1         system clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  bcd_data   in   4*DIGITS  packed nibbles; [3:0] = digit 0
//  dp_in      in   DIGITS    decimal point per digit; 1 = lit
//  load       in   1         1-clk strobe: capture bcd_data/dp_in
//  blank_lz   in   1         1 = blank leading zeros
//  seg7       out  8         active-low segments {dp,g,f,e,d,c,b,a}
//  dig_sel    out  DIGITS    one-hot digit enable, polarity set by DIG_ACT_LO
//  frame_done out  1         1-clk pulse when the scan wraps from digit DIGITS-1 to digit 0
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - div_cnt=0, idx=0, pend=0, pending/display regs=0
//   - seg7=8'hFF, dig_sel=all inactive, frame_done=0
//  Slot timing:
//   - div_cnt counts 0..SCAN_DIV-1.
//   - At div_cnt==SCAN_DIV-1: div_cnt->0 and idx advances; idx==DIGITS-1 wraps to 0.
//  Wrap edge (idx DIGITS-1->0; every slot end when DIGITS=1):
//   - frame_done=1 for that one clock.
//   - If load=1 on this edge: display<=inputs and pend stays 0.
//   - Else if pend=1: display<=pending and pend<=0.
//  Load (not at a wrap edge): pending<=inputs and pend<=1. Repeated loads keep the last one.
//  Update rule: the display never changes mid-frame.
//  Decode:
//   - 0..9: C0,F9,A4,B0,99,92,82,F8,80,90 (hex, dp bit off).
//   - HEX_EN=1: A=88, b=83, C=C6, d=A1, E=86, F=8E.
//   - HEX_EN=0: 10..15 give FF.
//   - seg7[7] = ~dp of the current digit.
//  Leading-zero blanking (blank_lz=1):
//   - Digit i is blanked if it and every digit above it equal 0. A blanked digit drives
//     segments [6:0]=7'h7F.
//   - dp is still shown on a blanked digit.
//   - Digit 0 is never blanked.
//  Outputs registered:
//   - seg7/dig_sel reflect the {idx,div_cnt} of the previous clock (1-clk latency).
//   - dig_sel is inactive while div_cnt<BLANK_CYC; otherwise only bit idx is active.
//   - seg7 is valid for the whole slot.
//  Reset mid-frame: everything returns to reset values at once; pending data is lost.
// TESTING (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, DIG_ACT_LO=1 unless stated)
//  1. Release reset with bcd_data=16'h0000 -> seg7=FF and dig_sel=4'hF during reset.
//     After reset: digit 0 shows C0; dig_sel=4'hE from clk 3 to clk 8 of the slot.
//  2. load with 16'h1234, dp_in=4'b0010 mid-frame -> old value held until the frame_done
//     edge. Next frame shows digit0=99, digit1=30 (dp lit), digit2=A4, digit3=F9.
//  3. blank_lz=1, data 16'h0070 -> digits 3 and 2 give FF, digit1=F8, digit0=C0.
//     With data 16'h0000, only digit 0 is lit (C0).
//  4. HEX_EN=0 vs 1 with data 16'hABCD -> all digits FF vs digit3..0 = 88,83,C6,A1.
//  5. load asserted on the wrap clock, then a second load mid-frame -> the first value
//     shows at once; the second shows only at the next frame_done.
//  6. rst_n low in mid-slot of digit 2 with pend=1 -> seg7=FF at once.
//     After release, scan restarts at digit 0 with display=0; the pending value is dropped.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver: double-buffered digits, frame-aligned
// updates, leading-zero blanking and a per-slot blanking window against ghosting.
module seg7_scan_mux #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 2,
  parameter int HEX_EN     = 0,
  parameter int DIG_ACT_LO = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [7:0]            seg7,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACT_LO != 0) ? '1 : '0;

  logic [CW-1:0]         div_cnt_q, div_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  pend_q;
  logic [4*DIGITS-1:0]   pend_data_q, disp_data_q;
  logic [DIGITS-1:0]     pend_dp_q, disp_dp_q;
  logic [7:0]            seg7_q, seg7_d;
  logic [DIGITS-1:0]     dig_sel_q, dig_sel_d;
  logic                  frame_done_q;

  logic                  slot_end, wrap;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_blank;
  logic [DIGITS-1:0]     lz_blank;
  logic                  zero_above;
  logic [DIGITS-1:0]     onehot;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'h7F;
    case (nib)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      4'd10: s = (HEX_EN != 0) ? 7'h08 : 7'h7F;
      4'd11: s = (HEX_EN != 0) ? 7'h03 : 7'h7F;
      4'd12: s = (HEX_EN != 0) ? 7'h46 : 7'h7F;
      4'd13: s = (HEX_EN != 0) ? 7'h21 : 7'h7F;
      4'd14: s = (HEX_EN != 0) ? 7'h06 : 7'h7F;
      4'd15: s = (HEX_EN != 0) ? 7'h0E : 7'h7F;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign slot_end = (div_cnt_q == CNT_LAST);
  assign wrap     = slot_end && (idx_q == IDX_LAST);

  always_comb begin
    div_cnt_d = slot_end ? '0 : div_cnt_q + CW'(1);
    idx_d     = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
  end

  // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    lz_blank   = '0;
    zero_above = blank_lz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above & (disp_data_q[4*i +: 4] == 4'd0);
      lz_blank[i] = zero_above;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib   = disp_data_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blank = lz_blank[i];
      end
    end
    seg7_d = {~cur_dp, cur_blank ? 7'h7F : decode(cur_nib)};
    onehot = DIGITS'(1) << idx_q;
    if (int'(div_cnt_q) < BLANK_CYC) dig_sel_d = DIG_OFF;
    else                             dig_sel_d = (DIG_ACT_LO != 0) ? ~onehot : onehot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      seg7_q       <= 8'hFF;
      dig_sel_q    <= DIG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      seg7_q       <= seg7_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= wrap;
      // The visible buffer only changes on the frame wrap so a frame is never torn.
      if (wrap) begin
        if (load) begin
          disp_data_q <= bcd_data;
          disp_dp_q   <= dp_in;
          pend_q      <= 1'b0;
        end else if (pend_q) begin
          disp_data_q <= pend_data_q;
          disp_dp_q   <= pend_dp_q;
          pend_q      <= 1'b0;
        end
      end else if (load) begin
        pend_data_q <= bcd_data;
        pend_dp_q   <= dp_in;
        pend_q      <= 1'b1;
      end
    end
  end

  assign seg7       = seg7_q;
  assign dig_sel    = dig_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: two instances (decimal-only and hex) share stimulus; a
// frame-level reference model predicts every registered output clock by clock.
module tb_seg7_scan_mux;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] bcd_data = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [7:0]  seg7_a, seg7_h;
  logic [3:0]  dig_sel_a, dig_sel_h;
  logic        fd_a, fd_h;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  logic [20:0] exp_q[$];
  logic [20:0] exp_w;
  int          ld_edge[$];
  logic [15:0] ld_data[$];
  logic [3:0]  ld_dp[$];

  seg7_scan_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC),
                  .HEX_EN(0), .DIG_ACT_LO(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bcd_data(bcd_data), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .seg7(seg7_a), .dig_sel(dig_sel_a), .frame_done(fd_a));

  seg7_scan_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC),
                  .HEX_EN(1), .DIG_ACT_LO(1)) u_dut_hex (
    .clk(clk), .rst_n(rst_n), .bcd_data(bcd_data), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .seg7(seg7_h), .dig_sel(dig_sel_h), .frame_done(fd_h));

  // clock / reset
  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Reference model: segment pattern for digit d of a displayed word.
  function automatic logic [7:0] exp_seg(input logic [15:0] data, input logic [3:0] dp,
                                         input int d, input logic blz, input logic hex);
    int upper, nib;
    logic [7:0] v;
    upper = int'(data) >> (4 * d);
    nib   = upper % 16;
    case (nib)
      0: v = 8'hC0;  1: v = 8'hF9;  2: v = 8'hA4;  3: v = 8'hB0;
      4: v = 8'h99;  5: v = 8'h92;  6: v = 8'h82;  7: v = 8'hF8;
      8: v = 8'h80;  9: v = 8'h90;
      10: v = hex ? 8'h88 : 8'hFF;
      11: v = hex ? 8'h83 : 8'hFF;
      12: v = hex ? 8'hC6 : 8'hFF;
      13: v = hex ? 8'hA1 : 8'hFF;
      14: v = hex ? 8'h86 : 8'hFF;
      default: v = hex ? 8'h8E : 8'hFF;
    endcase
    if (blz && d > 0 && upper == 0) v = 8'hFF;
    v[7] = ~dp[d];
    return v;
  endfunction

  // Frame f shows the newest load taken on or before the clock edge that starts it.
  function automatic logic [19:0] frame_value(input int f);
    for (int i = ld_edge.size() - 1; i >= 0; i--)
      if (ld_edge[i] <= f * FRAME - 1) return {ld_dp[i], ld_data[i]};
    return 20'h0;
  endfunction

  // driver: one clock; called at a falling edge, returns at the next one
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p);
    logic [19:0] fv;
    logic [3:0]  one, ds;
    int          digit, phase;
    logic        fd;
    load     = ld;
    bcd_data = ld ? d : 16'($urandom);
    dp_in    = ld ? p : 4'($urandom);
    if (ld) begin
      ld_edge.push_back(k);
      ld_data.push_back(d);
      ld_dp.push_back(p);
    end
    fv    = frame_value(k / FRAME);
    digit = (k / SCAN_DIV) % DIGITS;
    phase = k % SCAN_DIV;
    one   = 4'b0001 << digit;
    ds    = (phase < BLANK_CYC) ? 4'hF : ~one;
    fd    = (k % FRAME) == FRAME - 1;
    exp_q.push_back({fd, ds, exp_seg(fv[15:0], fv[19:16], digit, blank_lz, 1'b1),
                     exp_seg(fv[15:0], fv[19:16], digit, blank_lz, 1'b0)});
    k++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, 4'h0);
  endtask

  task automatic check_reset_outputs();
    check8("rst_seg7", seg7_a, 8'hFF);
    check8("rst_seg7_hex", seg7_h, 8'hFF);
    check8("rst_dig_sel", {4'h0, dig_sel_a}, 8'h0F);
    check8("rst_dig_sel_hex", {4'h0, dig_sel_h}, 8'h0F);
    check8("rst_frame_done", {7'h0, fd_a}, 8'h00);
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_w = exp_q.pop_front();
      check8("seg7", seg7_a, exp_w[7:0]);
      check8("seg7_hex", seg7_h, exp_w[15:8]);
      check8("dig_sel", {4'h0, dig_sel_a}, {4'h0, exp_w[19:16]});
      check8("dig_sel_hex", {4'h0, dig_sel_h}, {4'h0, exp_w[19:16]});
      check8("frame_done", {7'h0, fd_a}, {7'h0, exp_w[20]});
      check8("frame_done_hex", {7'h0, fd_h}, {7'h0, exp_w[20]});
    end
  end

  initial begin
    logic [31:0] r;
    #1 rst_n = 1'b0;
    #3 check_reset_outputs();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    k = 0;

    idle(40);
    step(1'b1, 16'h1234, 4'b0010);
    idle(80);

    blank_lz = 1'b1;
    step(1'b1, 16'h0070, 4'b0000);
    idle(70);
    step(1'b1, 16'h0000, 4'b0000);
    idle(70);
    step(1'b1, 16'h0005, 4'b1100);
    idle(70);
    blank_lz = 1'b0;

    step(1'b1, 16'hABCD, 4'b0000);
    idle(70);

    while (k % FRAME != FRAME - 1) idle(1);
    step(1'b1, 16'h5678, 4'b0001);
    idle(10);
    step(1'b1, 16'h9EF0, 4'b1000);
    idle(60);

    repeat (800) begin
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 11) == 0) begin
        r = $urandom & (32'hFFFF >> (4 * $urandom_range(0, 4)));
        step(1'b1, r[15:0], 4'($urandom));
      end else begin
        idle(1);
      end
    end

    blank_lz = 1'b0;
    while (k % FRAME != 0) idle(1);
    idle(2);
    step(1'b1, 16'h4321, 4'b1111);
    while (k % FRAME != 2 * SCAN_DIV + 3) idle(1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    k = 0;
    ld_edge.delete();
    ld_data.delete();
    ld_dp.delete();
    idle(80);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
